ysyx_22041071_axi_w_arb: RTL and testbench

YSYX_22041071_AXI_W_ARB -- requirements
Module: ysyx_22041071_axi_w_arb

---
 rtl/ysyx_22041071_axi_w_arb_if.sv | 54 +++++
 rtl/ysyx_22041071_axi_w_arb.sv | 117 +++++++++++
 tb/tb_ysyx_22041071_axi_w_arb.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041071_axi_w_arb_if.sv
// Signal bundle shared by the two write requesters, the write arbiter and the downstream AXI write master.
// The master modport is the arbiter's view. The slave modport is the environment's view (requesters plus downstream).
interface ysyx_22041071_axi_w_arb_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4,
    parameter int RESP_W = 2
);
    logic              m0_aw_valid;
    logic [ADDR_W-1:0] m0_addr;
    logic [LEN_W-1:0]  m0_len;
    logic [1:0]        m0_size;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_grant;
    logic              m0_done;
    logic [RESP_W-1:0] m0_resp;

    logic              m1_aw_valid;
    logic [ADDR_W-1:0] m1_addr;
    logic [LEN_W-1:0]  m1_len;
    logic [1:0]        m1_size;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_grant;
    logic              m1_done;
    logic [RESP_W-1:0] m1_resp;

    logic              s_aw_valid;
    logic [ID_W-1:0]   s_id;
    logic [ADDR_W-1:0] s_addr;
    logic [LEN_W-1:0]  s_len;
    logic [1:0]        s_size;
    logic [DATA_W-1:0] s_wdata;
    logic              s_aw_ready;
    logic [RESP_W-1:0] s_resp;

    modport master (
        input  m0_aw_valid, m0_addr, m0_len, m0_size, m0_wdata,
        input  m1_aw_valid, m1_addr, m1_len, m1_size, m1_wdata,
        output m0_grant, m0_done, m0_resp,
        output m1_grant, m1_done, m1_resp,
        output s_aw_valid, s_id, s_addr, s_len, s_size, s_wdata,
        input  s_aw_ready, s_resp
    );

    modport slave (
        output m0_aw_valid, m0_addr, m0_len, m0_size, m0_wdata,
        output m1_aw_valid, m1_addr, m1_len, m1_size, m1_wdata,
        input  m0_grant, m0_done, m0_resp,
        input  m1_grant, m1_done, m1_resp,
        input  s_aw_valid, s_id, s_addr, s_len, s_size, s_wdata,
        output s_aw_ready, s_resp
    );
endinterface

// File: rtl/ysyx_22041071_axi_w_arb.sv
// Two-requester round-robin arbiter in front of a single AXI write master.
// The downstream side is tracked only through s_aw_ready, which is high exactly when the downstream master is idle.
//
// state | meaning
// IDLE  | no owner; arbitrate any pending request
// REQ   | s_aw_valid high, waiting for the downstream to accept
// BUSY  | accepted; waiting for the downstream to go busy (ready low)
// RESP  | downstream busy; ready returning high completes the transfer
module ysyx_22041071_axi_w_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4,
    parameter int RESP_W = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    ysyx_22041071_axi_w_arb_if.master      bus
);
    typedef enum logic [1:0] {IDLE, REQ, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic              grant_q, grant_nxt;
    logic              last_q, last_nxt;
    logic [RESP_W-1:0] resp0_q, resp1_q;
    logic              winner;
    logic              done;
    logic              active;
    logic [ADDR_W-1:0] addr_mux;
    logic [LEN_W-1:0]  len_mux;
    logic [1:0]        size_mux;
    logic [DATA_W-1:0] wdata_mux;

    // Round-robin: under contention, the requester that did not finish last wins.
    always_comb begin
        if (bus.m0_aw_valid && bus.m1_aw_valid) begin
            winner = ~last_q;
        end else begin
            winner = bus.m1_aw_valid;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        last_nxt  = last_q;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.m0_aw_valid || bus.m1_aw_valid) begin
                    grant_nxt = winner;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.s_aw_ready) state_nxt = BUSY;
            end
            BUSY: begin
                if (!bus.s_aw_ready) state_nxt = RESP;
            end
            RESP: begin
                if (bus.s_aw_ready) begin
                    done      = 1'b1;
                    last_nxt  = grant_q;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            resp0_q <= '0;
            resp1_q <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            if (done && !grant_q) resp0_q <= bus.s_resp;
            if (done && grant_q)  resp1_q <= bus.s_resp;
        end
    end

    assign active = (state != IDLE);

    // Request fields are forced to zero in IDLE so nothing leaks downstream between owners.
    always_comb begin
        addr_mux  = '0;
        len_mux   = '0;
        size_mux  = '0;
        wdata_mux = '0;
        if (active) begin
            addr_mux  = grant_q ? bus.m1_addr  : bus.m0_addr;
            len_mux   = grant_q ? bus.m1_len   : bus.m0_len;
            size_mux  = grant_q ? bus.m1_size  : bus.m0_size;
            wdata_mux = grant_q ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    assign bus.s_aw_valid = (state == REQ);
    assign bus.s_id       = {{(ID_W-1){1'b0}}, grant_q};
    assign bus.s_addr     = addr_mux;
    assign bus.s_len      = len_mux;
    assign bus.s_size     = size_mux;
    assign bus.s_wdata    = wdata_mux;

    assign bus.m0_grant = active && !grant_q;
    assign bus.m1_grant = active && grant_q;
    assign bus.m0_done  = done && !grant_q;
    assign bus.m1_done  = done && grant_q;
    assign bus.m0_resp  = bus.m0_done ? bus.s_resp : resp0_q;
    assign bus.m1_resp  = bus.m1_done ? bus.s_resp : resp1_q;
endmodule

// File: tb/tb_ysyx_22041071_axi_w_arb.sv
// Directed bench for the two-requester AXI write arbiter.
// A small downstream model holds s_aw_ready low for ds_lat cycles after each accepted request.
module tb_ysyx_22041071_axi_w_arb;
    logic clk;
    logic reset_n;
    int   n_chk, n_err;
    int   n_d0, n_d1, n_both;

    bit         ds_block;
    int         ds_lat;
    logic [1:0] ds_resp;
    int         ds_cnt;
    bit         ds_pend;

    ysyx_22041071_axi_w_arb_if bus ();

    ysyx_22041071_axi_w_arb dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream model: it updates on the falling edge so that its outputs are stable at the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            bus.s_aw_ready = 1'b1;
            ds_cnt         = 0;
            ds_pend        = 1'b0;
        end else if (ds_pend) begin
            ds_pend        = 1'b0;
            bus.s_aw_ready = 1'b0;
            ds_cnt         = ds_lat;
        end else if (ds_cnt > 0) begin
            ds_cnt = ds_cnt - 1;
            if (ds_cnt == 0) begin
                bus.s_aw_ready = 1'b1;
                bus.s_resp     = ds_resp;
            end
        end else begin
            bus.s_aw_ready = !ds_block;
            if (bus.s_aw_valid && bus.s_aw_ready) ds_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        #2;
        if (bus.m0_done) n_d0++;
        if (bus.m1_done) n_d1++;
        if (bus.m0_done && bus.m1_done) n_both++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output int who, output logic [1:0] r);
        who = -1;
        r   = 2'b00;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.m0_done || bus.m1_done) begin
                who = bus.m1_done ? 1 : 0;
                r   = bus.m1_done ? bus.m1_resp : bus.m0_resp;
                break;
            end
        end
        if (who < 0) chk("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.s_aw_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int         who;
        logic [1:0] r;
        int         base;

        n_chk = 0; n_err = 0; n_d0 = 0; n_d1 = 0; n_both = 0;
        ds_block = 1'b0; ds_lat = 5; ds_resp = 2'b00; ds_cnt = 0; ds_pend = 1'b0;
        bus.s_aw_ready = 1'b1; bus.s_resp = 2'b00;
        bus.m0_aw_valid = 1'b0; bus.m0_addr = '0; bus.m0_len = '0; bus.m0_size = '0; bus.m0_wdata = '0;
        bus.m1_aw_valid = 1'b0; bus.m1_addr = '0; bus.m1_len = '0; bus.m1_size = '0; bus.m1_wdata = '0;
        reset_n = 1'b0;

        #3;
        chk("rst_s_aw_valid", bus.s_aw_valid, 0);
        chk("rst_grants", {bus.m0_grant, bus.m1_grant}, 0);
        chk("rst_dones", {bus.m0_done, bus.m1_done}, 0);
        chk("rst_resps", {bus.m0_resp, bus.m1_resp}, 0);
        chk("rst_s_addr", bus.s_addr, 0);
        chk("rst_s_id", bus.s_id, 0);
        tick(); tick();
        reset_n = 1'b1;

        // m0 alone: single 8-byte beat
        bus.m0_addr = 64'h8000_0010; bus.m0_len = 8'd0; bus.m0_size = 2'b11;
        bus.m0_wdata = 64'hdead_beef_0123_4567;
        bus.m0_aw_valid = 1'b1;
        base = n_d0;
        chk("idle_no_valid", bus.s_aw_valid, 0);
        tick();
        chk("req_valid", bus.s_aw_valid, 1);
        chk("req_addr", bus.s_addr, 64'h8000_0010);
        chk("req_id", bus.s_id, 0);
        chk("req_size", bus.s_size, 2'b11);
        chk("req_wdata", bus.s_wdata, 64'hdead_beef_0123_4567);
        chk("req_grants", {bus.m0_grant, bus.m1_grant}, 2'b10);
        wait_done(who, r);
        chk("m0_done_who", who, 0);
        chk("m0_done_resp", r, 0);
        bus.m0_aw_valid = 1'b0;
        tick(); tick(); tick();
        chk("m0_one_pulse", n_d0 - base, 1);
        chk("idle_addr_zero", bus.s_addr, 0);

        // Contention right after reset: m0 first, then alternate.
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        bus.m1_addr = 64'h9000_0020; bus.m1_len = 8'd3; bus.m1_size = 2'b10;
        bus.m1_wdata = 64'h1111_2222_3333_4444;
        bus.m0_aw_valid = 1'b1; bus.m1_aw_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(who, r);
            chk($sformatf("rr_order%0d", k), who, k % 2);
        end
        bus.m0_aw_valid = 1'b0; bus.m1_aw_valid = 1'b0;
        tick(); tick();
        chk("rr_no_both_done", n_both, 0);

        // m1 alone with an error response that must be held.
        ds_resp = 2'b10;
        bus.m1_aw_valid = 1'b1;
        tick();
        chk("m1_req_id", bus.s_id, 1);
        chk("m1_req_addr", bus.s_addr, 64'h9000_0020);
        chk("m1_req_len", bus.s_len, 3);
        wait_done(who, r);
        chk("m1_err_who", who, 1);
        chk("m1_err_resp", r, 2'b10);
        bus.m1_aw_valid = 1'b0;
        ds_resp = 2'b00;
        tick(); tick(); tick();
        chk("m1_resp_hold", bus.m1_resp, 2'b10);
        chk("m1_done_low", bus.m1_done, 0);

        // Downstream stalls in REQ: the request must stay asserted and stable.
        ds_block = 1'b1;
        bus.m0_aw_valid = 1'b1;
        wait_req();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("stall_valid%0d", k), bus.s_aw_valid, 1);
            chk($sformatf("stall_addr%0d", k), bus.s_addr, 64'h8000_0010);
        end
        ds_block = 1'b0;
        wait_done(who, r);
        chk("stall_done_who", who, 0);
        bus.m0_aw_valid = 1'b0;
        tick();

        // Asynchronous reset while BUSY aborts the transfer without a completion pulse.
        ds_lat = 20;
        base = n_d0;
        bus.m0_aw_valid = 1'b1;
        wait_req();
        tick();
        chk("busy_grant", bus.m0_grant, 1);
        chk("busy_valid_low", bus.s_aw_valid, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_grant", bus.m0_grant, 0);
        chk("async_rst_addr", bus.s_addr, 0);
        chk("async_rst_size", bus.s_size, 0);
        chk("async_rst_done", bus.m0_done, 0);
        bus.m0_aw_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        ds_lat = 5;
        tick(); tick(); tick();
        chk("abort_no_done", n_d0 - base, 0);
        bus.m1_aw_valid = 1'b1;
        chk("restart_idle_grant", bus.m1_grant, 0);
        tick();
        chk("restart_req_valid", bus.s_aw_valid, 1);
        chk("restart_req_grant", bus.m1_grant, 1);
        wait_done(who, r);
        chk("restart_done_who", who, 1);
        bus.m1_aw_valid = 1'b0;
        tick();

        // m1 drops its request while BUSY; the transfer still completes once.
        base = n_d1;
        bus.m1_aw_valid = 1'b1;
        wait_req();
        tick();
        chk("drop_busy_grant", bus.m1_grant, 1);
        bus.m1_aw_valid = 1'b0;
        wait_done(who, r);
        chk("drop_done_who", who, 1);
        tick(); tick();
        chk("drop_one_pulse", n_d1 - base, 1);
        chk("final_no_both_done", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
